// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32 instruction encoder.
// Immediate-format coding matches the immediate extender.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -(1 << 20);
    localparam int IMM21_MAX = (1 << 20) - 2;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packer: builds the 32-bit word for the selected format
// and flags whether the immediate fits that format.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        instr = '0;
        legal = 1'b0;
        unique case (imm_src_e'(imm_src))
            IMM_I: begin
                legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
                instr = {imm[11:0], rs1, funct3, rd, opcode};
            end
            IMM_S: begin
                legal = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            IMM_B: begin
                // Branch offsets are halfword-aligned; bit 0 is not encodable.
                legal = (simm >= IMM13_MIN) && (simm <= IMM13_MAX) && !imm[0];
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            IMM_J: begin
                legal = (simm >= IMM21_MIN) && (simm <= IMM21_MAX) && !imm[0];
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: S1 captures fields, S2 holds the packed word
// with its sequential address. Illegal immediates are dropped and counted.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          imm_src,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [31:0]         imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [31:0]         out_instr,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic                s1_v_q;
    logic [1:0]          s1_src_q;
    logic [6:0]          s1_opcode_q;
    logic [2:0]          s1_funct3_q;
    logic [4:0]          s1_rd_q;
    logic [4:0]          s1_rs1_q;
    logic [4:0]          s1_rs2_q;
    logic [31:0]         s1_imm_q;

    logic                s2_v_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [31:0]         out_instr_q;
    logic [ADDR_W-1:0]   addr_cnt_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;

    logic [31:0]         packed_instr;
    logic                packed_legal;
    logic                s1_move;
    logic                accept;

    instr_encoder_imm_pack u_imm_pack (
        .imm_src (s1_src_q),
        .opcode  (s1_opcode_q),
        .funct3  (s1_funct3_q),
        .rd      (s1_rd_q),
        .rs1     (s1_rs1_q),
        .rs2     (s1_rs2_q),
        .imm     (s1_imm_q),
        .instr   (packed_instr),
        .legal   (packed_legal)
    );

    assign s1_move  = s1_v_q && (!s2_v_q || out_ready);
    // clr blocks acceptance so nothing is captured into a pipe that is being flushed.
    assign in_ready = !clr && (!s1_v_q || s1_move);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_src_q    <= '0;
            s1_opcode_q <= '0;
            s1_funct3_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_imm_q    <= '0;
            s2_v_q      <= 1'b0;
            out_addr_q  <= BaseAddr;
            out_instr_q <= '0;
            addr_cnt_q  <= BaseAddr;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else if (clr) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            out_addr_q <= BaseAddr;
            addr_cnt_q <= BaseAddr;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (accept) begin
                s1_v_q      <= 1'b1;
                s1_src_q    <= imm_src;
                s1_opcode_q <= opcode;
                s1_funct3_q <= funct3;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_imm_q    <= imm;
            end else if (s1_move) begin
                s1_v_q <= 1'b0;
            end

            if (s2_v_q && out_ready) begin
                s2_v_q <= 1'b0;
            end

            if (s1_move) begin
                if (packed_legal) begin
                    s2_v_q      <= 1'b1;
                    out_instr_q <= packed_instr;
                    out_addr_q  <= addr_cnt_q;
                    addr_cnt_q  <= addr_cnt_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_addr  = out_addr_q;
    assign out_instr = out_instr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + random bench for instr_encoder; a second instance with narrow
// address/error counters shares the stimulus to exercise wrap and saturation.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_instr;
    logic        err;
    logic [7:0]  err_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [1:0]  out_addr2;
    logic [31:0] out_instr2;
    logic        err2;
    logic [1:0]  err_cnt2;

    instr_encoder dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .err(err), .err_cnt(err_cnt)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .ERRCNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .imm_src(imm_src), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2),
        .out_instr(out_instr2), .err(err2), .err_cnt(err_cnt2)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] instr;
        logic        use_ext;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_addr;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference immediate extender: the decoder this encoder must invert.
    function automatic logic [31:0] ext(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'b00:   ext = {{20{i[31]}}, i[31:20]};
            2'b01:   ext = {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   ext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: ext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && !clr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_addr", 32'(out_addr), 32'(mon_e.addr));
                if (mon_e.use_ext) chk("round_trip", ext(out_instr, mon_e.src), mon_e.imm);
                else               chk("out_instr", out_instr, mon_e.instr);
                chk("narrow_valid", 32'(out_valid2), 32'd1);
                chk("narrow_addr", 32'(out_addr2), 32'(mon_e.addr[1:0]));
            end
        end
    end

    // Starts and ends at posedge+1; returns the number of cycles waited for in_ready.
    task automatic send(input logic [1:0] s, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                        input logic [31:0] imm_v, input logic legal, input logic [31:0] e_instr,
                        input logic use_ext, output int waits);
        imm_src = s; opcode = opc; funct3 = f3; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; imm = imm_v;
        in_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 100);
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        if (legal) begin
            exp_q.push_back('{addr: exp_addr, instr: e_instr, use_ext: use_ext, src: s, imm: imm_v});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.delete();
        exp_addr = '0;
    endtask

    initial begin
        int w;
        int v;
        logic [1:0]  s;
        logic [31:0] iv;
        total = 0; bad = 0; exp_addr = '0;
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm_src = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        // lw x5,-4(x2): visible one edge after the accept edge
        send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 32'hFFC12283, 1'b0, w);
        chk("lw_lat_n", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lw_lat_n1", 32'(out_valid), 32'd1);
        chk("lw_instr", out_instr, 32'hFFC12283);
        drain();

        // S/B/J back-to-back
        do_clr();
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 32'h00512423, 1'b0, w);
        chk("stream_rdy_s", 32'(w), 32'd1);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0, w);
        chk("stream_rdy_b", 32'(w), 32'd1);
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF, 1'b0, w);
        chk("stream_rdy_j", 32'(w), 32'd1);
        drain();

        // illegal immediates are dropped and do not consume an address
        do_clr();
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0, 1'b0, w);
        send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'd4096, 1'b0, 32'd0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_err_cnt", 32'(err_cnt), 32'd2);
        chk("ill_no_out", 32'(out_valid), 32'd0);
        send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 32'hFFC12283, 1'b0, w);
        drain();

        // backpressure: two accepted, third held off, outputs stable
        do_clr();
        out_ready = 1'b0;
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 32'h00512423, 1'b0, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0, w);
        imm_src = 2'b11; opcode = 7'b1101111; funct3 = '0; rd = 5'd1; rs1 = '0; rs2 = '0;
        imm = 32'd2048;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_instr", out_instr, 32'h00512423);
            chk("bp_out_addr", 32'(out_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF, 1'b0, w);
        drain();

        // address wrap on the 2-bit instance
        do_clr();
        for (int i = 0; i < 5; i++) begin
            iv = 32'(i * 4);
            send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, iv, 1'b1,
                 {iv[11:0], 5'd2, 3'b010, 5'd5, 7'b0000011}, 1'b0, w);
        end
        drain();

        // error counter saturation on the 2-bit instance
        do_clr();
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0, 32'd5000, 1'b0, 32'd0, 1'b0, w);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sat_err_cnt_narrow", 32'(err_cnt2), 32'd3);
        chk("sat_err_cnt_wide", 32'(err_cnt), 32'd5);
        chk("sat_err_narrow", 32'(err2), 32'd1);

        // clr with both stages full; the word offered during clr is not taken
        do_clr();
        out_ready = 1'b0;
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 32'h00512423, 1'b0, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0, w);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_addr = '0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("clr_no_capture", 32'(out_valid), 32'd0);
        send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 32'hFFC12283, 1'b0, w);
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 32'h00512423, 1'b0, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, 1'b0, w);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_addr = '0;
        out_ready = 1'b1;
        send(2'b00, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 32'hFFC12283, 1'b0, w);
        drain();

        // random legal fields, checked by round trip through the extender
        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom_range(0, 3));
            case (s)
                2'b00, 2'b01: v = int'($urandom_range(0, 4095)) - 2048;
                2'b10:        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
                default:      v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            endcase
            send(s, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 32'(v), 1'b1, 32'd0, 1'b1, w);
        end
        drain();

        // range boundaries
        do_clr();
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2047, 1'b1, 32'd0, 1'b1, w);
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0, -32'sd2048, 1'b1, 32'd0, 1'b1, w);
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b0, 32'd0, 1'b0, w);
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2, -32'sd2049, 1'b0, 32'd0, 1'b0, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b1, 32'd0, 1'b1, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd4096, 1'b1, 32'd0, 1'b1, w);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 32'd0, 1'b0, w);
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1048574, 1'b1, 32'd0, 1'b1, w);
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, -32'sd1048576, 1'b1, 32'd0, 1'b1, w);
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1048576, 1'b0, 32'd0, 1'b0, w);
        send(2'b11, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0, 1'b0, w);
        drain();
        chk("bound_err_cnt", 32'(err_cnt), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
